// File: rtl/board_controller_pkg.sv
// Shared definitions for the tic-tac-toe board controller: board geometry,
// player / outcome / square codes, display colours and FSM state encodings.
package board_controller_pkg;

    localparam int N_SQUARES = 9;
    localparam int N_LINES   = 8;

    typedef logic [N_SQUARES-1:0] board_t;

    // Player codes as driven by the turn FSM.
    localparam logic [1:0] PLAYER_P1 = 2'b01;
    localparam logic [1:0] PLAYER_P2 = 2'b10;

    // Game outcome codes; 4..7 are never driven.
    localparam logic [2:0] OUT_IN_PROGRESS = 3'd0;
    localparam logic [2:0] OUT_P1_WIN      = 3'd1;
    localparam logic [2:0] OUT_P1_LOSE     = 3'd2;
    localparam logic [2:0] OUT_TIE         = 3'd3;

    // Square codes; board bit is (code - 1).
    localparam logic [3:0] SQ_A1 = 4'd1;
    localparam logic [3:0] SQ_A2 = 4'd2;
    localparam logic [3:0] SQ_A3 = 4'd3;
    localparam logic [3:0] SQ_B1 = 4'd4;
    localparam logic [3:0] SQ_B2 = 4'd5;
    localparam logic [3:0] SQ_B3 = 4'd6;
    localparam logic [3:0] SQ_C1 = 4'd7;
    localparam logic [3:0] SQ_C2 = 4'd8;
    localparam logic [3:0] SQ_C3 = 4'd9;

    // 12-bit RGB colours used by the display logic.
    localparam logic [11:0] COLOUR_P1      = 12'hF00;
    localparam logic [11:0] COLOUR_P2      = 12'h00F;
    localparam logic [11:0] COLOUR_DEFAULT = 12'h888;

    // FSM state encodings.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_VALIDATE = 3'd1;
    localparam logic [2:0] ST_WRITE    = 3'd2;
    localparam logic [2:0] ST_SCAN     = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    // True when a move code names a real square.
    function automatic logic is_square_code(input logic [3:0] code);
        return (code >= SQ_A1) && (code <= SQ_C3);
    endfunction

endpackage

// File: rtl/board_controller_win_line_rom.sv
// Win-line mask table: maps a line index 0..7 to the 9-bit set of squares
// forming that row, column or diagonal.
module win_line_rom
    import board_controller_pkg::*;
(
    input  logic [2:0] idx,
    output board_t     mask
);

    // Pure lookup: rows, then columns, then the two diagonals.
    always_comb begin
        // NOTE: a default before the case keeps this block free of latches.
        mask = '0;
        case (idx)
            3'd0: mask = 9'h007;
            3'd1: mask = 9'h038;
            3'd2: mask = 9'h1C0;
            3'd3: mask = 9'h049;
            3'd4: mask = 9'h092;
            3'd5: mask = 9'h124;
            3'd6: mask = 9'h111;
            3'd7: mask = 9'h054;
            default: mask = '0;
        endcase
    end

endmodule

// File: rtl/board_controller.sv
// Tic-tac-toe board controller: validates and commits one move per request,
// scans all eight win lines (one per clock, fixed latency) and reports the
// game outcome with a one-cycle done pulse.
module board_controller
    import board_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       req,
    input  logic [1:0] player,
    input  logic [3:0] move,
    output logic       busy,
    output logic       done,
    output logic       valid,
    output logic [2:0] outcome,
    output board_t     board_p1,
    output board_t     board_p2,
    output logic [3:0] move_count
);

    logic [2:0] state;
    logic [3:0] move_q;
    logic [1:0] player_q;
    logic       win_flag;
    logic [2:0] line_idx;

    board_t     line_mask;
    board_t     square_bit;
    board_t     mover_board;
    logic       line_hit;
    logic       win_next;
    logic       move_ok;

    win_line_rom u_win_line_rom (
        .idx  (line_idx),
        .mask (line_mask)
    );

    // Decode the latched request and evaluate the current win line.
    always_comb begin
        square_bit = '0;
        if (is_square_code(move_q)) begin
            square_bit = board_t'(1) << (move_q - 4'd1);
        end
        mover_board = (player_q == PLAYER_P1) ? board_p1 : board_p2;
        line_hit    = ((mover_board & line_mask) == line_mask);
        win_next    = win_flag | line_hit;
        move_ok     = is_square_code(move_q)
                   && ((player_q == PLAYER_P1) || (player_q == PLAYER_P2))
                   && (((board_p1 | board_p2) & square_bit) == '0)
                   && (outcome == OUT_IN_PROGRESS)
                   && (move_count < 4'd9);
    end

    assign busy = (state != ST_IDLE);

    // Move-processing FSM together with the board, count and outcome state.
    always_ff @(posedge clk) begin
        // NOTE: reset and clear are sampled on the clock edge (synchronous),
        // and all state uses non-blocking assignments.
        if (!rst || clear) begin
            state      <= ST_IDLE;
            move_q     <= '0;
            player_q   <= '0;
            win_flag   <= 1'b0;
            line_idx   <= '0;
            done       <= 1'b0;
            valid      <= 1'b0;
            outcome    <= OUT_IN_PROGRESS;
            board_p1   <= '0;
            board_p2   <= '0;
            move_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        move_q   <= move;
                        player_q <= player;
                        state    <= ST_VALIDATE;
                    end
                end
                ST_VALIDATE: begin
                    valid <= move_ok;
                    if (move_ok) begin
                        state <= ST_WRITE;
                    end else begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (player_q == PLAYER_P1) begin
                        board_p1 <= board_p1 | square_bit;
                    end else begin
                        board_p2 <= board_p2 | square_bit;
                    end
                    if (move_count < 4'd9) begin
                        move_count <= move_count + 4'd1;
                    end
                    win_flag <= 1'b0;
                    line_idx <= '0;
                    state    <= ST_SCAN;
                end
                ST_SCAN: begin
                    win_flag <= win_next;
                    if (line_idx == 3'd7) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        if (win_next) begin
                            outcome <= (player_q == PLAYER_P1) ? OUT_P1_WIN : OUT_P1_LOSE;
                        end else begin
                            outcome <= (move_count == 4'd9) ? OUT_TIE : OUT_IN_PROGRESS;
                        end
                    end else begin
                        line_idx <= line_idx + 3'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
